// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the processor run controller: command modes and FSM states.
// Combinational helper only; no latency, no flow control.
// Backpressure: not applicable.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_STOP  = 2'd0,
        MODE_STEP  = 2'd1,
        MODE_BURST = 2'd2,
        MODE_FREE  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BURST  = 2'd1,
        ST_FREE   = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    function automatic logic is_running(input state_e s);
        return (s == ST_BURST) || (s == ST_FREE);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running up counter with synchronous clear and a registered wrap pulse.
// Latency: value and wrap update one edge after inc/clr.
// Backpressure: none; inc is taken every edge it is high.
module wrap_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         wrap
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            // clear wins over a same-edge increment and never reports a wrap
            value <= '0;
            wrap  <= 1'b0;
        end else if (inc) begin
            value <= value + W'(1);
            wrap  <= &value;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/cycle_run_ctrl.sv
// Run controller gating the processor clock enable for STEP/BURST/FREE runs.
// Latency: command accepted at edge k drives cpu_en from cycle k+1; done one cycle after a run ends.
// Backpressure: cmd_ready low while running unless the offered command is STOP.
module cycle_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd_mode,
    input  logic [BURST_W-1:0] cmd_count,
    output logic               cmd_ready,
    input  logic               halt_req,
    input  logic               clr_count,
    output logic               cpu_en,
    output logic               busy,
    output logic               done,
    output logic               halted,
    output logic [CNT_W-1:0]   cycle_count,
    output logic               cnt_wrap
);

    state_e             state;
    logic [BURST_W-1:0] remaining;
    logic               done_q;
    mode_e              mode;
    logic               accept;

    state_e             start_state;
    logic [BURST_W-1:0] start_rem;
    logic               start_done;

    assign mode      = mode_e'(cmd_mode);
    assign busy      = is_running(state);
    assign cpu_en    = busy;
    assign halted    = (state == ST_HALTED);
    assign done      = done_q;
    assign cmd_ready = !busy || (mode == MODE_STOP);
    assign accept    = cmd_valid && cmd_ready;

    // Where a start command leads, shared by IDLE and by HALTED once halt_req drops.
    always_comb begin
        start_state = ST_IDLE;
        start_rem   = '0;
        start_done  = 1'b0;
        case (mode)
            MODE_STEP: begin
                start_state = ST_BURST;
                start_rem   = BURST_W'(1);
            end
            MODE_BURST: begin
                if (cmd_count != '0) begin
                    start_state = ST_BURST;
                    start_rem   = cmd_count;
                end else begin
                    start_done  = 1'b1;
                end
            end
            MODE_FREE: start_state = ST_FREE;
            default:   start_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= start_state;
                        remaining <= start_rem;
                        done_q    <= start_done;
                    end
                end
                ST_BURST, ST_FREE: begin
                    if (state == ST_BURST)
                        remaining <= remaining - BURST_W'(1);
                    // STOP beats halt, halt beats burst completion
                    if (accept) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end else if (halt_req) begin
                        state  <= ST_HALTED;
                        done_q <= 1'b1;
                    end else if (state == ST_BURST && remaining == BURST_W'(1)) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (mode == MODE_STOP) begin
                            state <= ST_IDLE;
                        end else if (!halt_req) begin
                            state     <= start_state;
                            remaining <= start_rem;
                            done_q    <= start_done;
                        end
                    end
                end
            endcase
        end
    end

    wrap_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (cpu_en),
        .clr   (clr_count),
        .value (cycle_count),
        .wrap  (cnt_wrap)
    );

endmodule

// File: tb/tb_cycle_run_ctrl.sv
// Scoreboard bench: each run pushes its expected length, final count and halted flag;
// a monitor pops and compares on every done pulse.
module tb_cycle_run_ctrl;

    localparam int CW = 4;
    localparam int BW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic [1:0]    cmd_mode;
    logic [BW-1:0] cmd_count;
    logic          cmd_ready;
    logic          halt_req;
    logic          clr_count;
    logic          cpu_en, busy, done, halted, cnt_wrap;
    logic [CW-1:0] cycle_count;

    cycle_run_ctrl #(.CNT_W(CW), .BURST_W(BW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_mode(cmd_mode),
        .cmd_count(cmd_count), .cmd_ready(cmd_ready), .halt_req(halt_req),
        .clr_count(clr_count), .cpu_en(cpu_en), .busy(busy), .done(done),
        .halted(halted), .cycle_count(cycle_count), .cnt_wrap(cnt_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int cnt;
        bit hlt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   acc = 0;
    int   wraps_exp = 0;
    int   wraps_seen = 0;
    int   run_len = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Reference model: a run of n executed cycles.
    task automatic expect_run(input int n, input bit hlt);
        exp_t e;
        wraps_exp += (acc + n) / (1 << CW);
        acc = (acc + n) % (1 << CW);
        e.len = n;
        e.cnt = acc;
        e.hlt = hlt;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else begin
            if (cnt_wrap) wraps_seen++;
            if (cpu_en) run_len++;
            if (done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no done");
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("run_len", run_len, e.len);
                    check("count_at_done", cycle_count, e.cnt);
                    check("halted_at_done", halted, e.hlt);
                end
                run_len = 0;
            end
        end
    end

    // Called one unit after an edge; returns one unit after the accepting edge.
    task automatic issue(input logic [1:0] m, input int n);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_count = BW'(n);
        @(negedge clk);
        check("cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'd0;
        cmd_count = '0;
    endtask

    task automatic wait_done(input int budget);
        int b = 0;
        while (q.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got %0d runs pending expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        clr_count = 1'b1;
        @(posedge clk);
        #1;
        clr_count = 1'b0;
        acc = 0;
    endtask

    initial begin
        int w0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_count = '0;
        halt_req = 1'b0; clr_count = 1'b0;
        #12;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_halted", halted, 0);
        check("rst_wrap", cnt_wrap, 0);
        check("rst_count", cycle_count, 0);
        check("rst_ready", cmd_ready, 1);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // BURST 5 with latency check on the first enabled cycle
        expect_run(5, 0);
        issue(2'd2, 5);
        check("burst_latency", cpu_en, 1);
        wait_done(20);
        check("burst5_count", cycle_count, 5);

        // three single steps
        clear_cnt();
        for (int i = 0; i < 3; i++) begin
            expect_run(1, 0);
            issue(2'd1, 0);
            wait_done(10);
        end
        check("step3_count", cycle_count, 3);

        // FREE, halt after 7 cycles, ignored burst while halted, resume
        clear_cnt();
        issue(2'd3, 0);
        repeat (7) begin @(posedge clk); #1; end
        halt_req = 1'b1;
        expect_run(8, 1);
        wait_done(10);
        issue(2'd2, 2);
        repeat (3) begin @(posedge clk); #1; end
        check("halt_ignored_en", cpu_en, 0);
        check("halt_ignored_halted", halted, 1);
        check("halt_ignored_count", cycle_count, 8);
        halt_req = 1'b0;
        expect_run(2, 0);
        issue(2'd2, 2);
        wait_done(10);
        check("resume_count", cycle_count, 10);

        // STOP together with halt_req goes idle, not halted
        clear_cnt();
        issue(2'd3, 0);
        repeat (3) begin @(posedge clk); #1; end
        halt_req = 1'b1;
        expect_run(4, 0);
        issue(2'd0, 0);
        wait_done(10);
        halt_req = 1'b0;
        check("stop_halt_halted", halted, 0);
        check("stop_halt_busy", busy, 0);

        // wrap on a 4-bit counter
        clear_cnt();
        w0 = wraps_seen;
        wraps_exp = 0;
        expect_run(17, 0);
        issue(2'd2, 17);
        wait_done(40);
        check("wrap_pulses", wraps_seen - w0, 1);
        check("wrap_count", cycle_count, 1);

        // clear on the same edge as an increment
        clear_cnt();
        issue(2'd3, 0);
        repeat (2) begin @(posedge clk); #1; end
        clr_count = 1'b1;
        @(posedge clk); #1;
        clr_count = 1'b0;
        check("clr_vs_inc", cycle_count, 0);
        q.push_back('{len: 4, cnt: 1, hlt: 1'b0});
        acc = 1;
        issue(2'd0, 0);
        wait_done(10);
        check("clr_no_wrap", wraps_seen - w0, 1);

        // BURST 0: done next cycle, no enable
        expect_run(0, 0);
        issue(2'd2, 0);
        check("burst0_done", done, 1);
        check("burst0_en", cpu_en, 0);
        wait_done(10);

        // randomized runs
        clear_cnt();
        for (int i = 0; i < 10; i++) begin
            int r, n;
            r = $urandom_range(0, 2);
            if (r == 0) begin
                n = $urandom_range(0, 20);
                expect_run(n, 0);
                issue(2'd2, n);
            end else if (r == 1) begin
                expect_run(1, 0);
                issue(2'd1, 0);
            end else begin
                n = $urandom_range(1, 6);
                issue(2'd3, 0);
                repeat (n) begin @(posedge clk); #1; end
                expect_run(n + 1, 0);
                issue(2'd0, 0);
            end
            wait_done(40);
            check("rand_count", cycle_count, acc);
        end
        check("wraps_total", wraps_seen - w0, wraps_exp);

        // reset in the middle of a burst
        issue(2'd2, 10);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_count", cycle_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("post_rst_busy", busy, 0);
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cycle_run_ctrl.md
CYCLE_RUN_CTRL -- requirements
Module: cycle_run_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the retired-cycle counter.
REQ-002 Parameter BURST_W, default 16, width of the burst length field.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port cmd_valid  input  1  command offered.
REQ-006 Port cmd_mode  input  2  0 STOP, 1 STEP, 2 BURST, 3 FREE.
REQ-007 Port cmd_count  input  BURST_W  cycle count for BURST; ignored otherwise.
REQ-008 Port cmd_ready  output  1  command accepted on an edge where cmd_valid and cmd_ready are both 1.
REQ-009 Port halt_req  input  1  processor halt request, level.
REQ-010 Port clr_count  input  1  synchronous clear of cycle_count.
REQ-011 Port cpu_en  output  1  processor clock enable; each high cycle is one executed processor cycle.
REQ-012 Port busy  output  1  high in BURST or FREE.
REQ-013 Port done  output  1  one-cycle pulse when a run ends.
REQ-014 Port halted  output  1  high while in HALTED.
REQ-015 Port cycle_count  output  CNT_W  total cpu_en cycles since reset or clear.
REQ-016 Port cnt_wrap  output  1  one-cycle pulse when cycle_count wraps from all-ones to 0.

Function
REQ-017 FSM states IDLE, BURST, FREE, HALTED; cpu_en = busy = (state is BURST or FREE), decoded from the state register only.
REQ-018 cmd_ready is 1 in IDLE and HALTED; in BURST/FREE it is 1 only when cmd_mode is STOP.
REQ-019 IDLE: accepted STEP enters BURST with remaining=1; BURST with cmd_count=N>0 enters BURST with remaining=N; FREE enters FREE; STOP stays IDLE, no done.
REQ-020 BURST with cmd_count=0 stays IDLE; done pulses in the following cycle; cpu_en never asserts.
REQ-021 Latency: command accepted at edge k gives cpu_en high from cycle k+1; BURST N gives exactly N consecutive cpu_en cycles.
REQ-022 Every edge with cpu_en high decrements remaining (BURST only) and increments cycle_count.
REQ-023 BURST with remaining=1 at an edge with cpu_en high goes to IDLE; done high the next cycle.
REQ-024 halt_req high at an edge with cpu_en high: that cycle counts; state goes to HALTED; done pulses; halt takes priority over burst completion.
REQ-025 Accepted STOP while running: that cycle counts; state goes to IDLE; done pulses; STOP takes priority over halt_req.
REQ-026 HALTED: STOP goes to IDLE with no done; STEP/BURST/FREE are accepted but ignored while halt_req=1, and start per REQ-019 when halt_req=0.
REQ-027 cycle_count wraps modulo 2^CNT_W; cnt_wrap pulses in the cycle after the wrapping edge.
REQ-028 clr_count has priority over increment; the result is 0 with no cnt_wrap.

Reset
REQ-029 While rst_n=0: state IDLE, remaining 0, cycle_count 0; cpu_en, busy, done, halted and cnt_wrap are all 0; cmd_ready is 1.
REQ-030 Reset asserted mid-run drops cpu_en immediately (asynchronous) with no done pulse.

Structure
REQ-031 Mode encodings and state encodings are defined once in the shared package/header run_ctrl_pkg.
REQ-032 The cycle counter is the sub-module wrap_counter (parameter W; inputs inc and clr; outputs value and wrap pulse).

Verification
REQ-033 Reset, then BURST cmd_count=5 -> cpu_en high exactly 5 cycles starting the cycle after acceptance; done once; cycle_count=5.
REQ-034 STEP three times from IDLE -> three isolated one-cycle cpu_en pulses; cycle_count=3; three done pulses.
REQ-035 FREE, halt_req raised after 7 cpu_en cycles -> HALTED, cycle_count=8, halted=1; BURST 2 with halt_req=1 is ignored; after halt_req drops, BURST 2 gives cycle_count=10.
REQ-036 FREE then STOP together with halt_req -> IDLE, not HALTED; done pulses once.
REQ-037 CNT_W=4: BURST 17 -> cnt_wrap pulses once after the 16th cycle; final cycle_count=1; clr_count with an increment on the same edge -> 0.
REQ-038 BURST cmd_count=0 -> no cpu_en, done after 1 cycle; rst_n low mid-BURST -> cpu_en 0 immediately, no done.
